// File: rtl/spi_slave_shifter_pkg.sv
// Shared constants and FSM encoding for the SPI slave shifter.
package spi_slave_shifter_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 8;
    localparam int unsigned APB_ADDR_WIDTH = 12;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_ACTIVE = 2'd2
    } spi_state_e;

    // SPI modes as {cpol, cpha}
    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

endpackage

// File: rtl/spi_slave_shifter_sync.sv
// N-stage synchroniser with a one-cycle delayed copy for edge detection.
module spi_sync_edge #(
    parameter int unsigned STAGES  = 2,
    parameter logic        RST_VAL = 1'b0
) (
    input  logic PCLK,
    input  logic PRESETn,
    input  logic d_i,
    output logic q_o,
    output logic q_d_o
);

    logic [STAGES-1:0] sync_q;
    logic              dly_q;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            sync_q <= {STAGES{RST_VAL}};
            dly_q  <= RST_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            dly_q  <= sync_q[STAGES-1];
        end
    end

    assign q_o   = sync_q[STAGES-1];
    assign q_d_o = dly_q;

endmodule

// File: rtl/spi_slave_shifter.sv
// SPI slave serialiser/deserialiser, all four CPOL/CPHA modes, MSB/LSB first,
// oversampled on PCLK (PCLK >= 4x sclk).
module spi_slave_shifter
    import spi_slave_shifter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  cpol,
    input  logic                  cpha,
    input  logic                  lsbfe,
    input  logic                  sclk,
    input  logic                  ss,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  miso_oe,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_load,
    output logic                  tx_empty,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  underrun,
    output logic                  busy
);

    localparam int unsigned CW = $clog2(DATA_WIDTH) + 1;
    localparam int unsigned IW = $clog2(DATA_WIDTH);

    logic sclk_s, sclk_d, ss_s, ss_d, mosi_s, mosi_d_unused;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .PCLK(PCLK), .PRESETn(PRESETn), .d_i(sclk), .q_o(sclk_s), .q_d_o(sclk_d)
    );
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
        .PCLK(PCLK), .PRESETn(PRESETn), .d_i(ss), .q_o(ss_s), .q_d_o(ss_d)
    );
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .PCLK(PCLK), .PRESETn(PRESETn), .d_i(mosi), .q_o(mosi_s), .q_d_o(mosi_d_unused)
    );

    spi_state_e            state_q, state_d;
    logic [DATA_WIDTH-1:0] tx_hold_q, tx_hold_d;
    logic                  tx_empty_q, tx_empty_d;
    logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
    logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  underrun_q, underrun_d;
    logic                  miso_q, miso_d;
    logic [CW-1:0]         bit_cnt_q, bit_cnt_d;

    logic                  lead, trail, sample_edge, shift_edge, frame_done;
    logic [IW-1:0]         idx;
    logic [DATA_WIDTH-1:0] load_val;

    always_comb begin
        state_d    = state_q;
        tx_hold_d  = tx_hold_q;
        tx_empty_d = tx_empty_q;
        tx_shift_d = tx_shift_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        underrun_d = 1'b0;
        miso_d     = miso_q;
        bit_cnt_d  = bit_cnt_q;

        lead        = (sclk_d == cpol) && (sclk_s != cpol);
        trail       = (sclk_d != cpol) && (sclk_s == cpol);
        sample_edge = cpha ? trail : lead;
        shift_edge  = cpha ? lead : trail;
        frame_done  = (bit_cnt_q == CW'(DATA_WIDTH));
        idx         = lsbfe ? bit_cnt_q[IW-1:0] : IW'(DATA_WIDTH - 1) - bit_cnt_q[IW-1:0];
        // A write landing in the LOAD cycle is taken directly into the shifter
        load_val    = tx_load ? tx_data : (tx_empty_q ? '0 : tx_hold_q);

        if (tx_load) begin
            tx_hold_d  = tx_data;
            tx_empty_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                miso_d    = 1'b0;
                bit_cnt_d = '0;
                if (ss_d && !ss_s) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                tx_shift_d = load_val;
                underrun_d = tx_empty_q && !tx_load;
                tx_empty_d = 1'b1;
                bit_cnt_d  = '0;
                if (!cpha) miso_d = lsbfe ? load_val[0] : load_val[DATA_WIDTH-1];
                state_d    = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (frame_done) begin
                    rx_data_d  = rx_shift_q;
                    rx_valid_d = 1'b1;
                    state_d    = ss_s ? ST_IDLE : ST_LOAD;
                    if (ss_s) miso_d = 1'b0;
                end else if (ss_s) begin
                    state_d = ST_IDLE;
                    miso_d  = 1'b0;
                end else if (sample_edge) begin
                    rx_shift_d[idx] = mosi_s;
                    bit_cnt_d       = bit_cnt_q + 1'b1;
                end else if (shift_edge) begin
                    miso_d = tx_shift_q[idx];
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q    <= ST_IDLE;
            tx_hold_q  <= '0;
            tx_empty_q <= 1'b1;
            tx_shift_q <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            underrun_q <= 1'b0;
            miso_q     <= 1'b0;
            bit_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            tx_hold_q  <= tx_hold_d;
            tx_empty_q <= tx_empty_d;
            tx_shift_q <= tx_shift_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            underrun_q <= underrun_d;
            miso_q     <= miso_d;
            bit_cnt_q  <= bit_cnt_d;
        end
    end

    assign miso     = miso_q;
    assign miso_oe  = !ss_s;
    assign tx_empty = tx_empty_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign underrun = underrun_q;
    assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_spi_slave_shifter.sv
// Directed bench: bit-banged SPI master against the slave shifter.
module tb_spi_slave_shifter;

    localparam int HALF = 4;

    logic       PCLK, PRESETn;
    logic       cpol, cpha, lsbfe, sclk, ss, mosi;
    logic       miso, miso_oe, tx_load, tx_empty, rx_valid, underrun, busy;
    logic [7:0] tx_data, rx_data;

    int checks = 0;
    int errors = 0;
    int rx_cnt = 0;
    int urun_cnt = 0;
    logic [7:0] rx_log [8];

    spi_slave_shifter #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .cpol(cpol), .cpha(cpha), .lsbfe(lsbfe),
        .sclk(sclk), .ss(ss), .mosi(mosi), .miso(miso), .miso_oe(miso_oe),
        .tx_data(tx_data), .tx_load(tx_load), .tx_empty(tx_empty),
        .rx_data(rx_data), .rx_valid(rx_valid), .underrun(underrun), .busy(busy)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    always @(negedge PCLK) begin
        if (rx_valid) begin
            rx_log[rx_cnt % 8] = rx_data;
            rx_cnt++;
        end
        if (underrun) urun_cnt++;
    end

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge PCLK);
        #1;
    endtask

    task automatic load(input logic [7:0] v);
        tx_data = v;
        tx_load = 1'b1;
        wait_clk(1);
        tx_load = 1'b0;
    endtask

    task automatic set_mode(input logic pol, input logic pha, input logic lsb);
        cpol  = pol;
        cpha  = pha;
        lsbfe = lsb;
        sclk  = pol;
        wait_clk(4);
    endtask

    // Master side: drives nbits of mo, returns the MISO bits in the same positions
    task automatic xfer(input int nbits, input logic [15:0] mo, input bit keep_ss,
                        output logic [15:0] mi);
        logic [15:0] m;
        int pos;
        m    = '0;
        sclk = cpol;
        ss   = 1'b0;
        wait_clk(8);
        for (int i = 0; i < nbits; i++) begin
            pos = (i / 8) * 8 + (lsbfe ? (i % 8) : (7 - (i % 8)));
            if (!cpha) begin
                mosi = mo[pos];
                wait_clk(HALF);
                sclk   = ~cpol;
                m[pos] = miso;
                wait_clk(HALF);
                sclk = cpol;
            end else begin
                sclk = ~cpol;
                mosi = mo[pos];
                wait_clk(HALF);
                sclk   = cpol;
                m[pos] = miso;
                wait_clk(HALF);
            end
        end
        wait_clk(HALF);
        if (!keep_ss) ss = 1'b1;
        mi = m;
    endtask

    logic [15:0] mi;
    int r0, u0;

    initial begin
        ss = 1'b1; sclk = 1'b0; mosi = 1'b0;
        cpol = 1'b0; cpha = 1'b0; lsbfe = 1'b0;
        tx_data = '0; tx_load = 1'b0;
        PRESETn = 1'b0;
        wait_clk(3);
        chk("rst_miso", miso, 0);
        chk("rst_miso_oe", miso_oe, 0);
        chk("rst_tx_empty", tx_empty, 1);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_underrun", underrun, 0);
        chk("rst_busy", busy, 0);
        PRESETn = 1'b1;
        wait_clk(2);

        // Mode 0, MSB first
        set_mode(0, 0, 0);
        load(8'hA5);
        chk("t1_tx_full", tx_empty, 0);
        r0 = rx_cnt;
        xfer(8, 16'h003C, 0, mi);
        wait_clk(6);
        chk("t1_miso", mi, 16'h00A5);
        chk("t1_rx_data", rx_data, 8'h3C);
        chk("t1_rx_pulses", rx_cnt - r0, 1);
        chk("t1_tx_empty", tx_empty, 1);

        // Mode 3, LSB first
        set_mode(1, 1, 1);
        load(8'h81);
        r0 = rx_cnt;
        xfer(8, 16'h0096, 0, mi);
        wait_clk(6);
        chk("t2_miso", mi, 16'h0081);
        chk("t2_rx_data", rx_data, 8'h96);
        chk("t2_rx_pulses", rx_cnt - r0, 1);

        // Modes 1 and 2, MSB first
        set_mode(0, 1, 0);
        load(8'hF0);
        xfer(8, 16'h000F, 0, mi);
        wait_clk(6);
        chk("t3m1_miso", mi, 16'h00F0);
        chk("t3m1_rx_data", rx_data, 8'h0F);
        set_mode(1, 0, 0);
        load(8'hF0);
        xfer(8, 16'h000F, 0, mi);
        wait_clk(6);
        chk("t3m2_miso", mi, 16'h00F0);
        chk("t3m2_rx_data", rx_data, 8'h0F);

        // Back-to-back frames, second byte written during frame 1
        set_mode(0, 0, 0);
        load(8'h11);
        r0 = rx_cnt;
        u0 = urun_cnt;
        fork
            xfer(16, 16'hC33C, 0, mi);
            begin
                wait_clk(30);
                load(8'h22);
                wait_clk(70);
                chk("t4_no_underrun", urun_cnt - u0, 0);
                chk("t4_busy_frame2", busy, 1);
            end
        join
        wait_clk(6);
        chk("t4_miso", mi, 16'h2211);
        chk("t4_rx_pulses", rx_cnt - r0, 2);
        chk("t4_rx_first", rx_log[r0 % 8], 8'h3C);
        chk("t4_rx_second", rx_log[(r0 + 1) % 8], 8'hC3);

        // Underrun then abort after 4 bits
        wait_clk(4);
        r0 = rx_cnt;
        u0 = urun_cnt;
        xfer(4, 16'h00F0, 1, mi);
        chk("t5_underrun", urun_cnt - u0, 1);
        chk("t5_miso_zero", mi, 16'h0000);
        chk("t5_oe_active", miso_oe, 1);
        ss = 1'b1;
        wait_clk(4);
        chk("t5_busy", busy, 0);
        chk("t5_miso_oe", miso_oe, 0);
        chk("t5_miso", miso, 0);
        wait_clk(10);
        chk("t5_no_rx", rx_cnt - r0, 0);

        // Asynchronous reset after 5 bits
        load(8'h77);
        xfer(5, 16'h00FF, 1, mi);
        chk("t6_busy_pre", busy, 1);
        #3 PRESETn = 1'b0;
        #1;
        chk("t6_miso", miso, 0);
        chk("t6_miso_oe", miso_oe, 0);
        chk("t6_tx_empty", tx_empty, 1);
        chk("t6_rx_data", rx_data, 0);
        chk("t6_rx_valid", rx_valid, 0);
        chk("t6_underrun", underrun, 0);
        chk("t6_busy", busy, 0);
        ss   = 1'b1;
        sclk = cpol;
        wait_clk(3);
        PRESETn = 1'b1;
        wait_clk(4);
        r0 = rx_cnt;
        xfer(8, 16'h005A, 0, mi);
        wait_clk(6);
        chk("t6_rx_after", rx_data, 8'h5A);
        chk("t6_rx_pulses", rx_cnt - r0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_slave_shifter.md
Name: spi_slave_shifter

Overview:
- SPI slave-side serialiser/deserialiser: the far end of the core's master shifter.
- Receives MOSI and drives MISO under an external sclk/ss, supporting all four CPOL/CPHA modes and MSB/LSB-first ordering.
- Fully synchronous to PCLK; sclk, ss and mosi are oversampled through 2-FF synchronisers. Requires PCLK >= 4x sclk.
- Used as the SPI-slave peripheral core and as the loopback responder in core-level benches.

Parameters:
- DATA_WIDTH, 8, frame width in bits (matches APB/SPI register width).
- SYNC_STAGES, 2, synchroniser depth for sclk/ss/mosi (minimum 2).

Ports:
- PCLK  in  1  system clock.
- PRESETn  in  1  asynchronous, active-low reset.
- cpol  in  1  sclk idle level; quasi-static, changed only while ss high.
- cpha  in  1  0: sample on leading edge; 1: sample on trailing edge.
- lsbfe  in  1  1: LSB first; 0: MSB first.
- sclk  in  1  serial clock from master (asynchronous).
- ss  in  1  slave select, active-low (asynchronous).
- mosi  in  1  serial data in.
- miso  out  1  serial data out.
- miso_oe  out  1  output enable for MISO pad; 1 while synchronised ss low.
- tx_data  in  DATA_WIDTH  next byte to transmit.
- tx_load  in  1  1-cycle strobe; writes tx_data into the holding register.
- tx_empty  out  1  holding register empty.
- rx_data  out  DATA_WIDTH  last completed received byte.
- rx_valid  out  1  1-cycle pulse, rx_data updated.
- underrun  out  1  1-cycle pulse, frame started with an empty holding register.
- busy  out  1  frame in progress.

Behaviour:
Reset values:
- miso=0, miso_oe=0, tx_empty=1, rx_data=0, rx_valid=0, underrun=0, busy=0.
- Synchroniser flops for sclk reset to 0, ss to 1, mosi to 0.
- FSM resets to IDLE.

Edge detection:
- sclk_s = synchronised sclk; sclk_d = sclk_s delayed one cycle.
- Leading edge: sclk_d==cpol && sclk_s!=cpol.
- Trailing edge: the opposite transition.
- Sample edge = leading if cpha=0, trailing if cpha=1. Shift edge = the other one.
- Pad-to-detect latency: SYNC_STAGES+1 PCLK.

FSM:
- IDLE -> LOAD when ss_s falls.
- LOAD (1 cycle):
  - tx_shift <= holding if !tx_empty, else 0x00 with underrun pulse.
  - tx_empty <= 1; bit_cnt <= 0; busy=1.
  - cpha=0: miso <= first bit (bit 0 if lsbfe, else bit DATA_WIDTH-1).
- LOAD -> ACTIVE.
- ACTIVE, sample edge: rx_shift captures mosi_s at index bit_cnt (lsbfe) or DATA_WIDTH-1-bit_cnt; bit_cnt++.
- ACTIVE, shift edge:
  - cpha=1: miso <= bit at current index before sampling.
  - cpha=0: miso <= next bit; no update after the last sample.
- After the DATA_WIDTH-th sample:
  - Next cycle: rx_data <= assembled byte, rx_valid=1 for one cycle.
  - If ss_s still low, go to LOAD (back-to-back frame). Otherwise go to IDLE.
- ACTIVE -> IDLE on ss_s rising at any bit_cnt (abort):
  - Partial byte discarded; no rx_valid.
  - tx_shift contents lost; holding register untouched.
  - miso_oe=0, miso=0, busy=0.

tx_load:
- Any cycle: holding <= tx_data, tx_empty <= 0.
- Coincident with LOAD: the newly written data is taken (load wins), tx_empty ends 0→1, no underrun.

Other rules:
- Edges while ss_s high are ignored.
- cpol/cpha/lsbfe changes while busy are undefined and must not be exercised.
- bit_cnt width $clog2(DATA_WIDTH)+1; it never wraps, and the saturating compare ends the frame.

Decomposition:
- Shared package: DATA_WIDTH default, APB_ADDR_WIDTH, FSM state encoding (IDLE/LOAD/ACTIVE), SPI mode constants (MODE0..MODE3 as {cpol,cpha}).
- One sub-module: spi_sync_edge. N-stage synchroniser plus a delayed copy, with reset value as a parameter. Instantiated for sclk (edge outputs), ss and mosi.

Test Plan:
1. Mode 0, MSB first: tx_load 0xA5, master sends 0x3C. Required: miso bit sequence 1,0,1,0,0,1,0,1; rx_data=0x3C; single rx_valid pulse; tx_empty=1 after LOAD.
2. Mode 3, LSB first: tx_load 0x81, master sends 0x96. Required: miso sequence 1,0,0,0,0,0,0,1; rx_data=0x96.
3. Modes 1 and 2, MSB first, tx 0xF0 / rx 0x0F. Required: MISO valid at each master sample edge; rx_data=0x0F in both modes.
4. Back-to-back: ss held low for 16 sclk; tx_load 0x11, then 0x22 during frame 1. Required: MISO sends 0x11 then 0x22; two rx_valid pulses; no underrun.
5. Underrun plus abort: no tx_load, ss falls. Required: underrun pulse, MISO all zeros. Then ss rises after 4 sclk. Required: no rx_valid, busy=0, miso_oe=0 within SYNC_STAGES+2 cycles.
6. Async reset mid-frame after 5 bits. Required: all outputs at reset values immediately. Next full frame receives 0x5A correctly.
